plot_stream_fb_writer: RTL and testbench

// - Receiving end of the pixel plot stream {X, Y, Colour, Plot} driven by the

---
 rtl/plot_stream_fb_writer.sv | 137 +++++++++++++
 tb/tb_plot_stream_fb_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_stream_fb_writer.sv
// Pixel plot stream to framebuffer write port: range check, registered address
// computation, small FIFO to ride out RAM stalls, and frame drain signalling.
module plot_stream_fb_writer #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int DEPTH           = 4
) (
  input  logic        iClock,
  input  logic        iResetn,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [8:0]  iColour,
  input  logic        iPlot,
  input  logic        iFrameDone,
  input  logic        iRamBusy,
  output logic        oReady,
  output logic [14:0] oWrAddress,
  output logic [8:0]  oWrData,
  output logic        oWrEn,
  output logic        oDrained,
  output logic        oOverflow,
  output logic [7:0]  oDropCount
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [8:0]  X_LIM    = 9'(X_SCREEN_PIXELS);
  localparam logic [7:0]  Y_LIM    = 8'(Y_SCREEN_PIXELS);
  localparam logic [14:0] X_STRIDE = 15'(X_SCREEN_PIXELS);
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  function automatic logic [14:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return 15'(x) + 15'(y) * X_STRIDE;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state;
  logic          in_range;
  logic          plot_ok;
  logic          vld_p0;
  logic [23:0]   ent_p0;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;

  assign in_range = ({1'b0, iX} < X_LIM) && ({1'b0, iY} < Y_LIM);
  assign plot_ok  = iPlot && in_range;
  assign pop      = (count != '0) && !iRamBusy;
  // A full FIFO can still take the entry when the head leaves in the same cycle.
  assign push     = vld_p0 && ((count != FULL) || pop);
  assign oReady   = (count != FULL);

  // Stage p0: address multiply-add registered ahead of the FIFO
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= plot_ok;
    end
  end

  always_ff @(posedge iClock) begin
    if (plot_ok) begin
      ent_p0 <= {fb_addr(iX, iY), iColour};
    end
  end

  // FIFO storage
  always_ff @(posedge iClock) begin
    if (push) begin
      mem[wr_ptr] <= ent_p0;
    end
  end

  // Stage p1: pop into the write port, occupancy, flags and frame FSM
  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      oWrEn      <= 1'b0;
      oWrAddress <= '0;
      oWrData    <= '0;
      oDrained   <= 1'b0;
      oOverflow  <= 1'b0;
      oDropCount <= '0;
      state      <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end

      if (vld_p0 && !push) oOverflow <= 1'b1;
      if (iPlot && !in_range) oDropCount <= sat_inc8(oDropCount);

      oWrEn <= pop;
      if (pop) begin
        {oWrAddress, oWrData} <= mem[rd_ptr];
      end

      oDrained <= 1'b0;
      case (state)
        IDLE: begin
          if (iFrameDone) begin
            state <= DRAIN;
          end else if (plot_ok) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (iFrameDone) state <= DRAIN;
        end
        DRAIN: begin
          // Empty FIFO and empty p0 means the last write already went out.
          if ((count == '0) && !vld_p0) begin
            state    <= IDLE;
            oDrained <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_stream_fb_writer.sv
// Bench for plot_stream_fb_writer: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_plot_stream_fb_writer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        iResetn = 1'b0;
  logic [7:0]  iX = '0;
  logic [6:0]  iY = '0;
  logic [8:0]  iColour = '0;
  logic        iPlot = 1'b0;
  logic        iFrameDone = 1'b0;
  logic        iRamBusy = 1'b0;
  logic        oReady;
  logic [14:0] oWrAddress;
  logic [8:0]  oWrData;
  logic        oWrEn;
  logic        oDrained;
  logic        oOverflow;
  logic [7:0]  oDropCount;

  always #5 clk = ~clk;

  plot_stream_fb_writer #(
    .X_SCREEN_PIXELS(160),
    .Y_SCREEN_PIXELS(120),
    .DEPTH(DEPTH)
  ) dut (
    .iClock(clk),
    .iResetn(iResetn),
    .iX(iX),
    .iY(iY),
    .iColour(iColour),
    .iPlot(iPlot),
    .iFrameDone(iFrameDone),
    .iRamBusy(iRamBusy),
    .oReady(oReady),
    .oWrAddress(oWrAddress),
    .oWrData(oWrData),
    .oWrEn(oWrEn),
    .oDrained(oDrained),
    .oOverflow(oOverflow),
    .oDropCount(oDropCount)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a pixel accepted at one edge sits in a one-slot holding
  // area, joins the queue at the next edge, and leaves the queue on a free cycle.
  logic [23:0] q[$];
  int          pend_v  = 0;
  logic [23:0] pend_e  = '0;
  int          m_wren  = 0;
  int          m_addr  = 0;
  int          m_data  = 0;
  int          m_drn   = 0;
  int          m_ovf   = 0;
  int          m_drop  = 0;
  int          draining = 0;

  logic [23:0] wlog[$];
  int          wcyc[$];
  int          dcyc[$];

  typedef struct {
    int rstn, plot, fd, busy, x, y, c;
    int wren, addr, data, drained, ready, ovf, drop;
  } vec_t;
  vec_t tv[12];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  task automatic model_step(input int rstn, input int plot, input int fd,
                            input int busy, input int x, input int y, input int c);
    logic [23:0] e;
    if (rstn == 0) begin
      q.delete();
      pend_v = 0; m_wren = 0; m_addr = 0; m_data = 0;
      m_drn = 0; m_ovf = 0; m_drop = 0; draining = 0;
      return;
    end
    m_drn = 0;
    if (draining != 0) begin
      if (q.size() == 0 && pend_v == 0) begin
        m_drn = 1;
        draining = 0;
      end
    end else if (fd != 0) begin
      draining = 1;
    end
    if (q.size() > 0 && busy == 0) begin
      e = q.pop_front();
      m_wren = 1;
      m_addr = int'(e[23:9]);
      m_data = int'(e[8:0]);
    end else begin
      m_wren = 0;
    end
    if (pend_v != 0) begin
      if (q.size() < DEPTH) q.push_back(pend_e);
      else m_ovf = 1;
    end
    pend_v = 0;
    if (plot != 0) begin
      if (x < 160 && y < 120) begin
        pend_v = 1;
        pend_e = {15'(x + 160 * y), 9'(c)};
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endtask

  task automatic step(input int rstn, input int plot, input int fd, input int busy,
                      input int x, input int y, input int c);
    iResetn    = (rstn != 0);
    iPlot      = (plot != 0);
    iFrameDone = (fd != 0);
    iRamBusy   = (busy != 0);
    iX         = 8'(x);
    iY         = 7'(y);
    iColour    = 9'(c);
    @(posedge clk);
    #1;
    model_step(rstn, plot, fd, busy, x, y, c);
    chk("model_wren",    oWrEn,      m_wren);
    chk("model_addr",    oWrAddress, m_addr);
    chk("model_data",    oWrData,    m_data);
    chk("model_drained", oDrained,   m_drn);
    chk("model_ready",   oReady,     (q.size() < DEPTH) ? 1 : 0);
    chk("model_ovf",     oOverflow,  m_ovf);
    chk("model_drop",    oDropCount, m_drop);
    if (oWrEn) begin
      wlog.push_back({oWrAddress, oWrData});
      wcyc.push_back(cyc);
    end
    if (oDrained) dcyc.push_back(cyc);
    cyc++;
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    dcyc.delete();
  endtask

  initial begin
    tv[0]  = '{0,0,0,0,   0,  0,    0,  0,    0,    0, 0, 1, 0, 0};
    tv[1]  = '{1,1,0,0,   5,  2,'h1FF,  0,    0,    0, 0, 1, 0, 0};
    tv[2]  = '{1,0,0,0,   0,  0,    0,  0,    0,    0, 0, 1, 0, 0};
    tv[3]  = '{1,0,0,0,   0,  0,    0,  1,  325,'h1FF, 0, 1, 0, 0};
    tv[4]  = '{1,0,0,0,   0,  0,    0,  0,  325,'h1FF, 0, 1, 0, 0};
    tv[5]  = '{1,1,0,0, 159,119,'h0A5,  0,  325,'h1FF, 0, 1, 0, 0};
    tv[6]  = '{1,1,0,0, 160,  0,'h003,  0,  325,'h1FF, 0, 1, 0, 1};
    tv[7]  = '{1,1,0,0,   0,120,'h007,  1,19199,'h0A5, 0, 1, 0, 2};
    tv[8]  = '{1,0,0,0,   0,  0,    0,  0,19199,'h0A5, 0, 1, 0, 2};
    tv[9]  = '{1,0,1,0,   0,  0,    0,  0,19199,'h0A5, 0, 1, 0, 2};
    tv[10] = '{1,0,0,0,   0,  0,    0,  0,19199,'h0A5, 1, 1, 0, 2};
    tv[11] = '{1,0,0,0,   0,  0,    0,  0,19199,'h0A5, 0, 1, 0, 2};

    @(negedge clk);

    // Reset, single write latency, range boundaries, empty-frame drain
    foreach (tv[i]) begin
      step(tv[i].rstn, tv[i].plot, tv[i].fd, tv[i].busy, tv[i].x, tv[i].y, tv[i].c);
      chk($sformatf("tv%0d_wren", i),    oWrEn,      tv[i].wren);
      chk($sformatf("tv%0d_addr", i),    oWrAddress, tv[i].addr);
      chk($sformatf("tv%0d_data", i),    oWrData,    tv[i].data);
      chk($sformatf("tv%0d_drained", i), oDrained,   tv[i].drained);
      chk($sformatf("tv%0d_ready", i),   oReady,     tv[i].ready);
      chk($sformatf("tv%0d_ovf", i),     oOverflow,  tv[i].ovf);
      chk($sformatf("tv%0d_drop", i),    oDropCount, tv[i].drop);
    end

    // Full FIFO with a push landing on a pop cycle
    clear_logs();
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 20 + i, 5, 16 + i);
    chk("t4_ready_full", oReady, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("t4_ready_after_swap", oReady, 0);
    chk("t4_ovf", oOverflow, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("t4_nwrites", wlog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_addr%0d", i), (i < wlog.size()) ? int'(wlog[i][23:9]) : -1, 20 + i + 800);
      chk($sformatf("t4_data%0d", i), (i < wlog.size()) ? int'(wlog[i][8:0]) : -1, 16 + i);
    end
    chk("t4_ovf_end", oOverflow, 0);

    // Stall with six pixels: four kept, two lost
    clear_logs();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 10 + i, 3, i);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("t3_ready", oReady, 0);
    chk("t3_ovf", oOverflow, 1);
    chk("t3_no_write_while_busy", wlog.size(), 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("t3_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i), (i < wlog.size()) ? int'(wlog[i][23:9]) : -1, 490 + i);
      chk($sformatf("t3_data%0d", i), (i < wlog.size()) ? int'(wlog[i][8:0]) : -1, i);
    end

    // Frame drain with toggling busy and a second frame-done absorbed
    clear_logs();
    for (int k = 0; k < 20; k++) begin
      step(1, (k < 3) ? 1 : 0, (k == 3 || k == 5) ? 1 : 0, k % 2, 30 + k, 7, 100 + k);
    end
    chk("t5_nwrites", wcyc.size(), 3);
    chk("t5_ndrained", dcyc.size(), 1);
    chk("t5_gap", (dcyc.size() > 0 && wcyc.size() > 0) ? dcyc[0] - wcyc[wcyc.size() - 1] : -1, 1);

    // Reset with entries queued and flags set
    clear_logs();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 40 + i, 9, i);
    step(1, 1, 0, 1, 170, 9, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("t6_wren", oWrEn, 0);
    chk("t6_ready", oReady, 1);
    chk("t6_ovf", oOverflow, 0);
    chk("t6_drop", oDropCount, 0);
    chk("t6_drained", oDrained, 0);
    chk("t6_addr", oWrAddress, 0);
    chk("t6_data", oWrData, 0);
    clear_logs();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("t6_no_stale_write", wlog.size(), 0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(1, 1, 0, 0, 200, 0, 0);
    chk("drop_saturates", oDropCount, 255);
    chk("drop_no_writes", wlog.size(), 0);

    // Randomized traffic against the model
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) != 0) ? 1 : 0,
           ($urandom_range(0, 99) < 60) ? 1 : 0,
           ($urandom_range(0, 99) < 6) ? 1 : 0,
           ($urandom_range(0, 99) < 40) ? 1 : 0,
           int'($urandom_range(0, 175)),
           int'($urandom_range(0, 127)),
           int'($urandom_range(0, 511)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
